fetch_queue: RTL and testbench

//  Instruction fetch front-end for the 5-stage pipeline. Issues sequential instruction-memory

---
 rtl/fetch_queue.sv | 156 +++++++++++++++
 tb/tb_fetch_queue.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front-end. Issues sequential instruction-memory
// reads, buffers returned words with their PC in a small FIFO and presents the
// head to the IF stage over valid/ready. Supports redirect (flush + new PC) and
// stops fetching once the halt opcode (ins[31:26] == 6'b111111) comes back.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       start_pc,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              ins_valid,
    output logic [31:0]       ins,
    output logic [31:0]       ins_pc,
    input  logic              ins_ready,
    output logic              halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HALTED
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        pc;
    logic [31:0]        req_pc;
    logic               inflight;
    logic               squash;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [31:0]        word_mem [DEPTH];
    logic [31:0]        pc_mem   [DEPTH];

    logic               redir;
    logic               halt_ret;
    logic               push;
    logic               pop;
    logic [CNT_W:0]     occupancy;

    // Redirect has no effect while idle; start owns that state.
    assign redir     = redirect & (state != IDLE);
    assign halt_ret  = inflight & ~squash & (imem_rdata[31:26] == 6'h3F);
    // Slots already committed: buffered words plus the read whose data is returning now.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

    assign imem_req  = (state == FETCH) & (occupancy < (CNT_W + 1)'(DEPTH))
                     & ~halt_ret & ~redirect;
    assign imem_addr = pc[ADDR_W-1:0];

    // A redirect flushes the queue, so a same-cycle return or pop is discarded.
    assign push      = inflight & ~squash & ~redir;
    assign ins_valid = (count != '0);
    assign pop       = ins_valid & ins_ready & ~redir;
    assign ins       = word_mem[rd_ptr];
    assign ins_pc    = pc_mem[rd_ptr];
    assign halted    = (state == HALTED);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start leaves IDLE, halt return drains, redirect refetches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                if (redirect)      state_nxt = FETCH;
                else if (halt_ret) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (redirect)                         state_nxt = FETCH;
                else if ((count == '0) && !inflight)  state_nxt = HALTED;
            end
            HALTED: begin
                if (redirect) state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch PC, request PC and the one-deep in-flight/squash tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= '0;
            req_pc   <= '0;
            inflight <= 1'b0;
            squash   <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                pc <= start_pc;
            end else if (redir) begin
                pc <= redirect_pc;
            end else if (imem_req) begin
                pc <= pc + 32'd4;
            end
            if (imem_req) begin
                req_pc <= pc;
            end
            inflight <= imem_req;
            squash   <= redir ? inflight : 1'b0;
        end
    end

    // FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                word_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redir) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                word_mem[wr_ptr] <= imem_rdata;
                pc_mem[wr_ptr]   <= req_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios followed by randomized traffic, all checked
// cycle by cycle against a queue-based reference of the fetch front-end.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] start_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic        halted;

    fetch_queue #(.DEPTH(4), .ADDR_W(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_pc    (start_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instruction memory contents.
    logic [31:0] salt;
    bit          halt_en;
    logic [9:0]  halt_addr;

    // Reference model.
    typedef enum int { M_IDLE, M_FETCH, M_DRAIN, M_HALTED } mode_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] w; } ent_t;
    mode_t       m_mode;
    logic [31:0] m_pc;
    bit          m_infl;
    bit          m_squash;
    logic [31:0] m_infl_pc;
    logic [31:0] m_infl_word;
    ent_t        q[$];

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        if (halt_en && (a == halt_addr)) return 32'hFC00_0000;
        return salt ^ {22'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_pc     = '0;
        m_infl   = 0;
        m_squash = 0;
        q.delete();
    endtask

    // One clock cycle: check outputs before the edge, then advance the model
    // and drive the memory return for any request made in this cycle.
    task automatic step();
        bit          e_hret, e_req, s_start, s_redir, s_ready;
        logic [31:0] s_spc, s_rpc;
        int          pre_size;
        bit          pre_infl;
        @(negedge clk);
        #1;
        e_hret = m_infl && !m_squash && (m_infl_word[31:26] == 6'h3F);
        e_req  = (m_mode == M_FETCH) && ((q.size() + int'(m_infl)) < 4) && !e_hret && !redirect;
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("imem_addr", 32'(imem_addr), {22'h0, m_pc[9:0]});
        chk("ins_valid", 32'(ins_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("ins_pc", ins_pc, q[0].pc);
            chk("ins", ins, q[0].w);
        end
        chk("halted", 32'(halted), 32'(m_mode == M_HALTED));
        s_start = start;
        s_spc   = start_pc;
        s_redir = redirect;
        s_rpc   = redirect_pc;
        s_ready = ins_ready;
        @(posedge clk);
        #1;
        if (m_mode == M_IDLE) begin
            if (s_start) begin
                m_mode = M_FETCH;
                m_pc   = s_spc;
            end
            m_infl   = 0;
            m_squash = 0;
        end else if (s_redir) begin
            q.delete();
            m_pc     = s_rpc;
            m_squash = m_infl;
            m_infl   = 0;
            m_mode   = M_FETCH;
        end else begin
            pre_size = q.size();
            pre_infl = m_infl;
            if (pre_size > 0 && s_ready) void'(q.pop_front());
            if (m_infl && !m_squash) q.push_back({m_infl_pc, m_infl_word});
            if (m_mode == M_FETCH && e_hret) m_mode = M_DRAIN;
            else if (m_mode == M_DRAIN && pre_size == 0 && !pre_infl) m_mode = M_HALTED;
            m_squash = 0;
            if (e_req) begin
                m_infl      = 1;
                m_infl_pc   = m_pc;
                m_infl_word = mem_word(m_pc[9:0]);
                m_pc        = m_pc + 32'd4;
            end else begin
                m_infl = 0;
            end
        end
        imem_rdata = m_infl ? m_infl_word : $urandom();
        start    = 1'b0;
        redirect = 1'b0;
    endtask

    // Reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);
        chk("rst_ins_valid", 32'(ins_valid), 32'h0);
        chk("rst_ins", ins, 32'h0);
        chk("rst_ins_pc", ins_pc, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        model_reset();
        start      = 1'b0;
        redirect   = 1'b0;
        imem_rdata = $urandom();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        rst         = 1'b0;
        start       = 1'b0;
        start_pc    = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        ins_ready   = 1'b1;
        imem_rdata  = '0;
        salt        = '0;
        halt_en     = 0;
        halt_addr   = '0;
        model_reset();
        #1;
        chk("init_imem_req", 32'(imem_req), 32'h0);
        chk("init_ins_valid", 32'(ins_valid), 32'h0);
        chk("init_halted", 32'(halted), 32'h0);
        chk("init_ins_pc", ins_pc, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        step();

        // 1: sequential fetch, word = address, first delivery three cycles after start.
        start = 1'b1; start_pc = 32'h100;
        step();
        chk("t1_req_after_start", 32'(imem_req), 32'h1);
        chk("t1_addr_after_start", 32'(imem_addr), 32'h100);
        step();
        chk("t1_valid_early", 32'(ins_valid), 32'h0);
        step();
        chk("t1_valid_latency", 32'(ins_valid), 32'h1);
        chk("t1_first_pc", ins_pc, 32'h100);
        for (int i = 0; i < 12; i++) step();

        // 2: back-pressure fills the queue and stops requests, then drains in order.
        async_reset();
        ins_ready = 1'b0;
        start = 1'b1; start_pc = 32'h100;
        for (int i = 0; i < 9; i++) step();
        chk("t2_req_stalled", 32'(imem_req), 32'h0);
        chk("t2_head_pc", ins_pc, 32'h100);
        ins_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();

        // 3: redirect while full with a read in flight.
        async_reset();
        ins_ready = 1'b0;
        start = 1'b1; start_pc = 32'h100;
        for (int i = 0; i < 5; i++) step();
        ins_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        chk("t3_flushed", 32'(ins_valid), 32'h0);
        step();
        step();
        chk("t3_valid_after_redirect", 32'(ins_valid), 32'h1);
        chk("t3_first_pc", ins_pc, 32'h200);
        for (int i = 0; i < 10; i++) step();

        // 4: halt word at 0x108, then redirect out of HALTED.
        async_reset();
        halt_en = 1; halt_addr = 10'h108;
        start = 1'b1; start_pc = 32'h100;
        for (int i = 0; i < 30 && !halted; i++) step();
        chk("t4_halted", 32'(halted), 32'h1);
        step();
        step();
        redirect = 1'b1; redirect_pc = 32'h0;
        step();
        chk("t4_halted_cleared", 32'(halted), 32'h0);
        chk("t4_refetch_addr", 32'(imem_addr), 32'h0);
        for (int i = 0; i < 8; i++) step();
        halt_en = 0;

        // 5: reset mid-stream, then stay idle until started.
        ins_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        async_reset();
        for (int i = 0; i < 4; i++) step();

        // 6: PC wrap-around.
        ins_ready = 1'b1;
        start = 1'b1; start_pc = 32'hFFFF_FFFC;
        step();
        chk("t6_addr_top", 32'(imem_addr), 32'h3FC);
        step();
        chk("t6_addr_wrap", 32'(imem_addr), 32'h000);
        step();
        chk("t6_pc_top", ins_pc, 32'hFFFF_FFFC);
        step();
        chk("t6_pc_wrap", ins_pc, 32'h0000_0000);
        for (int i = 0; i < 4; i++) step();

        // 7: randomized traffic with halts, redirects and stray starts.
        async_reset();
        r = $urandom();
        salt = {6'h15, r[25:0]};
        halt_en = 1;
        r = $urandom();
        halt_addr = {r[9:2], 2'b00};
        for (int i = 0; i < 1500; i++) begin
            ins_ready = ($urandom_range(3) != 0);
            if (m_mode == M_HALTED || $urandom_range(40) == 0) begin
                r = $urandom();
                redirect    = 1'b1;
                redirect_pc = {r[31:2], 2'b00};
            end
            if (m_mode == M_IDLE || $urandom_range(15) == 0) begin
                r = $urandom();
                start    = 1'b1;
                start_pc = {r[31:2], 2'b00};
            end
            if (i == 700) async_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
